// File: rtl/rl_modexp_pkg.sv
// Shared types and timing helpers for the rl_modexp_w exponentiator.
package rl_modexp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        LOOP   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Cycles spent in one REDUCE or LOOP phase: one launch cycle plus W+1 wait cycles.
    function automatic int phase_cycles(input int w);
        return w + 2;
    endfunction

    // Cycles from the accepting edge to the done pulse for n loop iterations.
    function automatic int total_latency(input int w, input int n);
        return 1 + (n + 1) * phase_cycles(w);
    endfunction

endpackage

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier: p = (a * b) mod m.
// Scans a MSB-first, one bit per clock; done pulses W+1 cycles after start.
// Requires b < m; the running remainder stays below m so two subtractions suffice.
module mod_mul #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic         done,
    output logic [W-1:0] p
);
    localparam int CW = $clog2(W + 1);

    logic [W+1:0]  acc_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  m_q;
    logic [CW-1:0] cnt_q;

    logic [W+1:0]  m_ext;
    logic [W+1:0]  t_add;
    logic [W+1:0]  t_sub1;
    logic [W+1:0]  t_sub2;

    // One reduction step: double, add b if the current a bit is set, then reduce below m.
    always_comb begin
        m_ext  = {2'b00, m_q};
        t_add  = (acc_q << 1) + (a_q[W-1] ? {2'b00, b_q} : '0);
        t_sub1 = (t_add  >= m_ext) ? t_add  - m_ext : t_add;
        t_sub2 = (t_sub1 >= m_ext) ? t_sub1 - m_ext : t_sub1;
    end

    // Operand capture on start, then W steps; done is raised with the final step.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc_q <= '0;
                a_q   <= a;
                b_q   <= b;
                m_q   <= m;
                cnt_q <= CW'(W);
            end else if (cnt_q != '0) begin
                acc_q <= t_sub2;
                a_q   <= a_q << 1;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = acc_q[W-1:0];

endmodule

// File: rtl/rl_modexp_w.sv
// Right-to-left binary modular exponentiator: r = (base ^ exp) mod modulus.
// A squarer and a multiplier run side by side every iteration; the multiply
// always runs, so each iteration takes the same time regardless of exp bits.
// Optional macro RL_MODEXP_EARLY_EXIT_EN: stop after the highest set exp bit.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// REDUCE | squarer computes base mod modulus into y
// LOOP   | one iteration per exp bit: y <= y*y, r_acc <= r_acc*y if bit set
// FINISH | publish r/err, pulse done on the next edge, return to IDLE
module rl_modexp_w
    import rl_modexp_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    input  logic [W-1:0] modulus,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] r,
    output logic         err
);
    localparam int CW = $clog2(W + 1);

    state_t        state_q;
    state_t        state_d;

    logic [W-1:0]  base_q;
    logic [W-1:0]  exp_q;
    logic [W-1:0]  m_q;
    logic [W-1:0]  y_q;
    logic [W-1:0]  r_acc_q;
    logic [CW-1:0] i_q;
    logic [CW-1:0] n_q;
    logic [CW-1:0] n_calc;
    logic          wait_q;
    logic          err_pend_q;

    logic          accept;
    logic          sq_start;
    logic          mul_start;
    logic [W-1:0]  sq_a;
    logic [W-1:0]  sq_b;
    logic          commit;
    logic          fin;

    logic          sq_done;
    logic [W-1:0]  sq_p;
    logic          mul_done;
    logic [W-1:0]  mul_p;

    // Number of loop iterations for the operand being accepted.
    always_comb begin
        n_calc = CW'(W);
`ifdef RL_MODEXP_EARLY_EXIT_EN
        n_calc = '0;
        for (int k = 0; k < W; k++) begin
            if (exp[k]) begin
                n_calc = CW'(k + 1);
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (modulus == '0) ? FINISH : REDUCE;
                end
            end
            REDUCE: begin
                if (commit) begin
                    state_d = (n_q == '0) ? FINISH : LOOP;
                end
            end
            LOOP: begin
                if (commit && (i_q == n_q - CW'(1))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control strobes and squarer operand selection.
    always_comb begin
        accept    = (state_q == IDLE) && start;
        fin       = (state_q == FINISH);
        sq_start  = 1'b0;
        mul_start = 1'b0;
        sq_a      = y_q;
        sq_b      = y_q;
        commit    = 1'b0;
        case (state_q)
            REDUCE: begin
                sq_a     = base_q;
                sq_b     = W'(1);
                sq_start = !wait_q;
                commit   = wait_q && sq_done;
            end
            LOOP: begin
                sq_start  = !wait_q;
                mul_start = !wait_q;
                commit    = wait_q && sq_done && mul_done;
            end
            default: begin
            end
        endcase
    end

    // Datapath: operand capture, per-phase commit, and result publication.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_q     <= '0;
            exp_q      <= '0;
            m_q        <= '0;
            y_q        <= '0;
            r_acc_q    <= '0;
            i_q        <= '0;
            n_q        <= '0;
            wait_q     <= 1'b0;
            err_pend_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            r          <= '0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                base_q     <= base;
                exp_q      <= exp;
                m_q        <= modulus;
                n_q        <= n_calc;
                i_q        <= '0;
                y_q        <= '0;
                wait_q     <= 1'b0;
                // 1 mod m is 0 for m == 1; m == 0 also yields r = 0 with err.
                r_acc_q    <= (modulus > W'(1)) ? W'(1) : '0;
                err_pend_q <= (modulus == '0);
                busy       <= 1'b1;
            end
            if (sq_start) begin
                wait_q <= 1'b1;
            end
            if (commit) begin
                wait_q <= 1'b0;
                y_q    <= sq_p;
                if (state_q == LOOP) begin
                    if (exp_q[0]) begin
                        r_acc_q <= mul_p;
                    end
                    exp_q <= exp_q >> 1;
                    i_q   <= i_q + CW'(1);
                end
            end
            if (fin) begin
                r    <= r_acc_q;
                err  <= err_pend_q;
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    mod_mul #(.W(W)) u_sq (
        .clk   (clk),
        .rstn  (rstn),
        .start (sq_start),
        .a     (sq_a),
        .b     (sq_b),
        .m     (m_q),
        .done  (sq_done),
        .p     (sq_p)
    );

    mod_mul #(.W(W)) u_mul (
        .clk   (clk),
        .rstn  (rstn),
        .start (mul_start),
        .a     (r_acc_q),
        .b     (y_q),
        .m     (m_q),
        .done  (mul_done),
        .p     (mul_p)
    );

endmodule

// File: tb/tb_rl_modexp_w.sv
// Scoreboard bench for rl_modexp_w at W=32 and W=8.
module tb_rl_modexp_w;

    typedef struct {
        longint unsigned r;
        bit              err;
        int              lat;
        int              t0;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a = 1'b0;
    logic [31:0] base_a = '0, exp_a = '0, mod_a = '0;
    logic        busy_a, done_a, err_a;
    logic [31:0] r_a;

    logic        start_b = 1'b0;
    logic [7:0]  base_b = '0, exp_b = '0, mod_b = '0;
    logic        busy_b, done_b, err_b;
    logic [7:0]  r_b;

    rl_modexp_w #(.W(32)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a), .base(base_a), .exp(exp_a),
        .modulus(mod_a), .busy(busy_a), .done(done_a), .r(r_a), .err(err_a)
    );

    rl_modexp_w #(.W(8)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b), .base(base_b), .exp(exp_b),
        .modulus(mod_b), .busy(busy_b), .done(done_b), .r(r_b), .err(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t xa, xb;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    // Square-and-multiply over plain integers.
    function automatic longint unsigned ref_modexp(input longint unsigned b, input longint unsigned e,
                                                   input longint unsigned m, input int w);
        longint unsigned res, bb;
        if (m == 0) return 0;
        res = 1 % m;
        bb  = b % m;
        for (int k = 0; k < w; k++) begin
            if (((e >> k) & 1) == 1) res = (res * bb) % m;
            bb = (bb * bb) % m;
        end
        return res;
    endfunction

    function automatic int ref_lat(input longint unsigned e, input longint unsigned m, input int w);
        int n;
        if (m == 0) return 1;
        n = w;
`ifdef RL_MODEXP_EARLY_EXIT_EN
        n = 0;
        for (int k = 0; k < w; k++) if (((e >> k) & 1) == 1) n = k + 1;
`endif
        return 1 + (n + 1) * (w + 2);
    endfunction

    // Monitors: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rstn && done_a) begin
            if (q_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done_a_unexpected: got done=1, expected no pulse");
            end else begin
                xa = q_a.pop_front();
                chk("r_a", r_a, xa.r);
                chk("err_a", err_a, xa.err);
                chk("lat_a", cyc - xa.t0, xa.lat);
            end
        end
        if (rstn && done_b) begin
            if (q_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL done_b_unexpected: got done=1, expected no pulse");
            end else begin
                xb = q_b.pop_front();
                chk("r_b", r_b, xb.r);
                chk("err_b", err_b, xb.err);
                chk("lat_b", cyc - xb.t0, xb.lat);
            end
        end
    end

    // Returns on a negedge where the instance can take a start (done cycle included).
    task automatic wait_idle(input int sel);
        int budget = 3000;
        @(negedge clk);
        while (budget > 0) begin
            if (sel == 0 && !busy_a && (q_a.size() == 0 || done_a)) break;
            if (sel == 1 && !busy_b && (q_b.size() == 0 || done_b)) break;
            budget--;
            @(negedge clk);
        end
        if (budget == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle_timeout: got busy after 3000 cycles, expected idle (sel=%0d)", sel);
        end
    endtask

    task automatic issue(input int sel, input longint unsigned b, input longint unsigned e,
                         input longint unsigned m, input bit use_const, input longint unsigned rconst);
        exp_t x;
        int   w = (sel == 0) ? 32 : 8;
        wait_idle(sel);
        if (sel == 0) begin
            base_a = b[31:0]; exp_a = e[31:0]; mod_a = m[31:0]; start_a = 1'b1;
        end else begin
            base_b = b[7:0]; exp_b = e[7:0]; mod_b = m[7:0]; start_b = 1'b1;
        end
        @(negedge clk);
        x.t0  = cyc;
        x.r   = use_const ? rconst : ref_modexp(b, e, m, w);
        x.err = (m == 0);
        x.lat = ref_lat(e, m, w);
        if (sel == 0) begin
            start_a = 1'b0; base_a = $urandom; exp_a = $urandom; mod_a = $urandom;
            q_a.push_back(x);
            chk("busy_a_after_start", busy_a, 1);
        end else begin
            start_b = 1'b0; base_b = 8'($urandom); exp_b = 8'($urandom); mod_b = 8'($urandom);
            q_b.push_back(x);
            chk("busy_b_after_start", busy_b, 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected summary before 2 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        longint unsigned rb, re, rm;
        repeat (3) @(negedge clk);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_r_a", r_a, 0);
        chk("rst_err_a", err_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_r_b", r_b, 0);
        rstn = 1'b1;

        // Directed W=32 cases with known results.
        issue(0, 4, 13, 497, 1, 445);
        issue(0, 500, 13, 497, 1, 444);
        issue(0, 7, 0, 497, 1, 1);
        issue(0, 123456, 98765, 1, 1, 0);
        issue(0, 9, 9, 0, 1, 0);
        // Start during FINISH must be ignored.
        start_a = 1'b1; mod_a = 497; base_a = 3; exp_a = 5;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);

        // Start while busy must be ignored.
        issue(0, 4, 13, 497, 1, 445);
        repeat (50) @(negedge clk);
        start_a = 1'b1; base_a = 2; exp_a = 3; mod_a = 11;
        @(negedge clk);
        start_a = 1'b0;

        // Directed W=8 cases.
        issue(1, 255, 255, 251, 1, 20);
        issue(1, 17, 0, 1, 1, 0);
        issue(1, 200, 0, 97, 1, 1);

        // Randomized cases against the model.
        for (int k = 0; k < 6; k++) begin
            rb = $urandom; re = $urandom; rm = (k == 0) ? 1 : $urandom;
            if (rm == 0) rm = 3;
            issue(0, rb, re, rm, 0, 0);
        end
        for (int k = 0; k < 10; k++) begin
            rb = $urandom_range(0, 255); re = $urandom_range(0, 255);
            rm = $urandom_range(0, 255);
            issue(1, rb, re, rm, 0, 0);
        end
        wait_idle(1);

        // Reset mid-LOOP abandons the operation.
        issue(0, 4, 13, 497, 1, 445);
        wait_idle(0);
        issue(0, 3, 7, 1000, 0, 0);
        repeat (200) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("midrst_busy_a", busy_a, 0);
        chk("midrst_done_a", done_a, 0);
        chk("midrst_r_a", r_a, 0);
        q_a.delete();
        rstn = 1'b1;
        issue(0, 500, 13, 497, 1, 444);

        wait_idle(0);
        repeat (2) @(negedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
